// File: rtl/fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : fifo_pkg                                              |
// | Brief    : Shared constants and Gray/binary conversion helpers   |
// |            for the asynchronous FIFO read and write controllers. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package fifo_pkg;

  // Default RAM address width; FIFO depth is 2**ADDSIZE.
  localparam int ADDSIZE   = 4;
  // Pointer width carries one extra wrap bit for full/empty.
  localparam int PTR_WIDTH = ADDSIZE + 1;
  // Working width of the converters. Any pointer up to CVT_WIDTH-1 bits
  // converts correctly when zero-extended, since leading zeros are
  // invariant under both transforms.
  localparam int CVT_WIDTH = 32;

  function automatic logic [CVT_WIDTH-1:0] bin2gray(input logic [CVT_WIDTH-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [CVT_WIDTH-1:0] gray2bin(input logic [CVT_WIDTH-1:0] g);
    logic [CVT_WIDTH-1:0] b;
    b[CVT_WIDTH-1] = g[CVT_WIDTH-1];
    for (int i = CVT_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_w2r.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sync_w2r                                              |
// | Brief    : Two-flop synchroniser bringing the Gray write pointer |
// |            into the read clock domain.                           |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sync_w2r #(
  parameter int PTRW = fifo_pkg::PTR_WIDTH
) (
  input  logic            clk_rd,
  input  logic            rstn,
  input  logic [PTRW-1:0] wptr,
  output logic [PTRW-1:0] rq2_wptr
);
  import fifo_pkg::*;

  logic [PTRW-1:0] rq1_wptr_q;
  logic [PTRW-1:0] rq2_wptr_q;

  // Gray coding guarantees at most one bit is in flight, so a plain
  // two-stage flop chain yields either the old or the new pointer.
  always_ff @(posedge clk_rd or negedge rstn) begin
    if (!rstn) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
    end else begin
      rq1_wptr_q <= wptr;
      rq2_wptr_q <= rq1_wptr_q;
    end
  end

  assign rq2_wptr = rq2_wptr_q;

endmodule
`default_nettype wire

// File: rtl/rptr_empty.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rptr_empty                                            |
// | Brief    : Read-side pointer, empty, level and almost-empty      |
// |            controller of the asynchronous FIFO.                  |
// | Options  : `define RD_UNDERFLOW_FLAG_EN adds the sticky          |
// |            runderflow output (read attempted while empty).       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module rptr_empty #(
  parameter int ADDSIZE   = fifo_pkg::ADDSIZE,
  parameter int AE_THRESH = 1
) (
  input  logic               clk_rd,
  input  logic               rstn,
  input  logic               rinc,
  input  logic [ADDSIZE:0]   wptr,
`ifdef RD_UNDERFLOW_FLAG_EN
  output logic               runderflow,
`endif
  output logic [ADDSIZE-1:0] raddr,
  output logic [ADDSIZE:0]   rptr,
  output logic               rempty,
  output logic [ADDSIZE:0]   rlevel,
  output logic               ralmost_empty
);
  import fifo_pkg::*;

  localparam int            PW          = ADDSIZE + 1;
  localparam logic [PW-1:0] C_AE_THRESH = PW'(AE_THRESH);

  logic [PW-1:0]        rq2_wptr;
  logic                 ren;
  logic [PW-1:0]        rbin_q,   rbin_d;
  logic [PW-1:0]        rptr_q,   rptr_d;
  logic [PW-1:0]        rlevel_q, rlevel_d;
  logic                 rempty_q, rempty_d;
  logic                 rae_q,    rae_d;
  logic [PW-1:0]        wbin_s;
  logic [CVT_WIDTH-1:0] gray_full;
  logic [CVT_WIDTH-1:0] wbin_full;
  logic                 unused_cvt;

  sync_w2r #(
    .PTRW (PW)
  ) u_sync_w2r (
    .clk_rd   (clk_rd),
    .rstn     (rstn),
    .wptr     (wptr),
    .rq2_wptr (rq2_wptr)
  );

  // Next pointer, its Gray form, and the flags/level it implies against
  // the synchronised write pointer; flags are judged on the post-read
  // pointer so the last read asserts empty on its own edge.
  always_comb begin
    ren       = rinc & ~rempty_q;
    rbin_d    = rbin_q + PW'(ren);
    gray_full = bin2gray(CVT_WIDTH'(rbin_d));
    rptr_d    = gray_full[PW-1:0];
    wbin_full = gray2bin(CVT_WIDTH'(rq2_wptr));
    wbin_s    = wbin_full[PW-1:0];
    rlevel_d  = wbin_s - rbin_d;
    rempty_d  = (rptr_d == rq2_wptr);
    rae_d     = (rlevel_d <= C_AE_THRESH);
  end

  // Upper converter bits are always zero for pointer-width operands.
  assign unused_cvt = ^{gray_full[CVT_WIDTH-1:PW], wbin_full[CVT_WIDTH-1:PW]};

  // Pointer and flag registers; reset leaves the FIFO empty.
  always_ff @(posedge clk_rd or negedge rstn) begin
    if (!rstn) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
    end
  end

`ifdef RD_UNDERFLOW_FLAG_EN
  logic runderflow_q;

  // Sticky record of any read attempted while empty.
  always_ff @(posedge clk_rd or negedge rstn) begin
    if (!rstn) begin
      runderflow_q <= 1'b0;
    end else begin
      runderflow_q <= runderflow_q | (rinc & rempty_q);
    end
  end

  assign runderflow = runderflow_q;
`endif

  assign raddr         = rbin_q[ADDSIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign rlevel        = rlevel_q;
  assign ralmost_empty = rae_q;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_rptr_empty                                         |
// | Brief    : Self-checking bench for rptr_empty (ADDSIZE=4,        |
// |            AE_THRESH=1); checks runderflow when                  |
// |            RD_UNDERFLOW_FLAG_EN is defined.                      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_rptr_empty;

  logic       clk_rd = 1'b0;
  logic       rstn   = 1'b0;
  logic       rinc   = 1'b0;
  logic [4:0] wptr   = '0;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rlevel;
  logic       ralmost_empty;
`ifdef RD_UNDERFLOW_FLAG_EN
  logic       runderflow;
`endif

  int total = 0;
  int bad   = 0;

  rptr_empty #(
    .ADDSIZE   (4),
    .AE_THRESH (1)
  ) dut (
    .clk_rd        (clk_rd),
    .rstn          (rstn),
    .rinc          (rinc),
    .wptr          (wptr),
`ifdef RD_UNDERFLOW_FLAG_EN
    .runderflow    (runderflow),
`endif
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty)
  );

  always #5 clk_rd = ~clk_rd;

  typedef struct {
    logic [4:0] w;
    logic       inc;
    logic [3:0] a;
    logic [4:0] p;
    logic       e;
    logic [4:0] l;
    logic       ae;
    logic       uf;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [4:0] g5(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_rd);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " raddr"},  32'(raddr),         0);
    check({tag, " rptr"},   32'(rptr),          0);
    check({tag, " rempty"}, 32'(rempty),        1);
    check({tag, " rlevel"}, 32'(rlevel),        0);
    check({tag, " ae"},     32'(ralmost_empty), 1);
`ifdef RD_UNDERFLOW_FLAG_EN
    check({tag, " uf"},     32'(runderflow),    0);
`endif
  endtask

  initial begin
    logic [4:0] prev_p;

    //           wptr  rinc  raddr rptr  empty lvl    ae    uf
    vecs[0]  = '{5'd0,  1'b0, 4'd0, 5'd0, 1'b1, 5'd0,  1'b1, 1'b0};
    vecs[1]  = '{5'd1,  1'b0, 4'd0, 5'd0, 1'b1, 5'd0,  1'b1, 1'b0};
    vecs[2]  = '{5'd1,  1'b0, 4'd0, 5'd0, 1'b1, 5'd0,  1'b1, 1'b0};
    vecs[3]  = '{5'd1,  1'b0, 4'd0, 5'd0, 1'b0, 5'd1,  1'b1, 1'b0};
    vecs[4]  = '{5'd7,  1'b0, 4'd0, 5'd0, 1'b0, 5'd1,  1'b1, 1'b0};
    vecs[5]  = '{5'd7,  1'b0, 4'd0, 5'd0, 1'b0, 5'd1,  1'b1, 1'b0};
    vecs[6]  = '{5'd7,  1'b0, 4'd0, 5'd0, 1'b0, 5'd5,  1'b0, 1'b0};
    vecs[7]  = '{5'd7,  1'b1, 4'd1, 5'd1, 1'b0, 5'd4,  1'b0, 1'b0};
    vecs[8]  = '{5'd7,  1'b1, 4'd2, 5'd3, 1'b0, 5'd3,  1'b0, 1'b0};
    vecs[9]  = '{5'd7,  1'b1, 4'd3, 5'd2, 1'b0, 5'd2,  1'b0, 1'b0};
    vecs[10] = '{5'd7,  1'b1, 4'd4, 5'd6, 1'b0, 5'd1,  1'b1, 1'b0};
    vecs[11] = '{5'd7,  1'b1, 4'd5, 5'd7, 1'b1, 5'd0,  1'b1, 1'b0};
    vecs[12] = '{5'd7,  1'b1, 4'd5, 5'd7, 1'b1, 5'd0,  1'b1, 1'b1};
    vecs[13] = '{5'd7,  1'b1, 4'd5, 5'd7, 1'b1, 5'd0,  1'b1, 1'b1};
    vecs[14] = '{5'd31, 1'b0, 4'd5, 5'd7, 1'b1, 5'd0,  1'b1, 1'b1};
    vecs[15] = '{5'd31, 1'b0, 4'd5, 5'd7, 1'b1, 5'd0,  1'b1, 1'b1};
    vecs[16] = '{5'd31, 1'b0, 4'd5, 5'd7, 1'b0, 5'd16, 1'b0, 1'b1};

    // Reset held with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      wptr = 5'($urandom);
      rinc = 1'($urandom);
      step();
      check_reset_vals($sformatf("rst_hold%0d", i));
    end
    wptr = '0;
    rinc = 1'b0;
    rstn = 1'b1;

    // Visibility latency, drain past empty, and a full FIFO.
    for (int i = 0; i < 17; i++) begin
      wptr = vecs[i].w;
      rinc = vecs[i].inc;
      step();
      check($sformatf("v%0d raddr", i),  32'(raddr),         32'(vecs[i].a));
      check($sformatf("v%0d rptr", i),   32'(rptr),          32'(vecs[i].p));
      check($sformatf("v%0d rempty", i), 32'(rempty),        32'(vecs[i].e));
      check($sformatf("v%0d rlevel", i), 32'(rlevel),        32'(vecs[i].l));
      check($sformatf("v%0d ae", i),     32'(ralmost_empty), 32'(vecs[i].ae));
      check($sformatf("v%0d inv", i),    32'(rempty),        32'(rlevel == 5'd0));
`ifdef RD_UNDERFLOW_FLAG_EN
      check($sformatf("v%0d uf", i),     32'(runderflow),    32'(vecs[i].uf));
`endif
    end

    // Streaming write/read pairs across pointer wrap: rbin starts at 5,
    // synchronised write pointer at 21.
    prev_p = rptr;
    for (int k = 1; k <= 40; k++) begin
      wptr = g5(21 + k);
      rinc = 1'b1;
      step();
      check($sformatf("wrap%0d raddr", k),  32'(raddr),  32'((5 + k) % 16));
      check($sformatf("wrap%0d rptr", k),   32'(rptr),   32'(g5(5 + k)));
      check($sformatf("wrap%0d onebit", k), 32'($countones(rptr ^ prev_p)), 1);
      check($sformatf("wrap%0d rempty", k), 32'(rempty), 0);
      check($sformatf("wrap%0d rlevel", k), 32'(rlevel), (k == 1) ? 15 : 14);
      check($sformatf("wrap%0d ae", k),     32'(ralmost_empty), 0);
`ifdef RD_UNDERFLOW_FLAG_EN
      check($sformatf("wrap%0d uf", k),     32'(runderflow), 1);
`endif
      prev_p = rptr;
    end
    rinc = 1'b0;

    // Asynchronous reset mid-cycle, without waiting for a clock edge.
    @(posedge clk_rd);
    #3;
    rstn = 1'b0;
    wptr = 5'($urandom);
    #1;
    check_reset_vals("rst_async");
    for (int i = 0; i < 2; i++) begin
      wptr = 5'($urandom);
      rinc = 1'($urandom);
      step();
      check_reset_vals($sformatf("rst_mid%0d", i));
    end
    wptr = '0;
    rinc = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_vals($sformatf("rst_rel%0d", i));
    end

    // Full from reset: Gray(16) with read pointer at 0.
    wptr = 5'b11000;
    step();
    step();
    check("full2 rempty", 32'(rempty), 1);
    step();
    check("full rlevel", 32'(rlevel),        16);
    check("full rempty", 32'(rempty),        0);
    check("full ae",     32'(ralmost_empty), 0);
    check("full rptr",   32'(rptr),          0);
    check("full raddr",  32'(raddr),         0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
